grid_coloring_enum: RTL and testbench

Sequential solution enumerator for the 2×3 grid graph (6 vertices, 2 colors, edges 0-1, 0-3, 1-2, 1-4, 2-5, 3-4, 4-5). It is the producer-side counterpart of the combinational validity checker used in the coloring benchmarks. On `start`, it sweeps all 64 candidate colorings, keeps the ones that are proper colorings and satisfy the caller's pinned vertex colors, and streams them out over a valid/ready interface. It feeds the checker and the equivalence benches with known-good colorings.

---
 rtl/grid_coloring_enum.sv | 116 +++++++++++
 tb/tb_grid_coloring_enum.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/grid_coloring_enum.sv
`default_nettype none
// ============================================================================
// Module      : grid_coloring_enum
// Description : Enumerates proper 2-colorings of the 2x3 grid graph that match
//               the caller's pinned vertex colors; streams them over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_coloring_enum #(
    parameter int MAX_SOL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] pin_mask,
    input  logic [5:0] pin_val,
    output logic       sol_valid,
    input  logic       sol_ready,
    output logic [5:0] sol_color,
    output logic [6:0] sol_count,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SCAN = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [6:0] c_MAX_SOL  = 7'(MAX_SOL);
    localparam logic [5:0] c_LAST     = 6'd63;

    logic [1:0] r_state;
    logic [5:0] r_cand;
    logic [5:0] r_pin_mask;
    logic [5:0] r_pin_val;

    logic       w_proper;
    logic       w_pin_ok;
    logic       w_hit;
    logic [6:0] w_count_next;
    logic       w_limit;

    // A proper 2-coloring needs every edge to join differently colored vertices.
    assign w_proper = (r_cand[0] ^ r_cand[1]) & (r_cand[0] ^ r_cand[3]) &
                      (r_cand[1] ^ r_cand[2]) & (r_cand[1] ^ r_cand[4]) &
                      (r_cand[2] ^ r_cand[5]) & (r_cand[3] ^ r_cand[4]) &
                      (r_cand[4] ^ r_cand[5]);
    assign w_pin_ok     = ((r_cand ^ r_pin_val) & r_pin_mask) == 6'd0;
    assign w_hit        = w_proper & w_pin_ok;
    assign w_count_next = (sol_count == 7'd127) ? sol_count : sol_count + 7'd1;
    assign w_limit      = (c_MAX_SOL != 7'd0) && (w_count_next == c_MAX_SOL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_cand     <= 6'd0;
            r_pin_mask <= 6'd0;
            r_pin_val  <= 6'd0;
            sol_valid  <= 1'b0;
            sol_color  <= 6'd0;
            sol_count  <= 7'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            r_state   <= c_IDLE;
            sol_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state    <= c_SCAN;
                        r_cand     <= 6'd0;
                        sol_count  <= 7'd0;
                        r_pin_mask <= pin_mask;
                        r_pin_val  <= pin_val;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                c_SCAN: begin
                    if (w_hit) begin
                        r_state   <= c_HOLD;
                        sol_color <= r_cand;
                        sol_valid <= 1'b1;
                    end else if (r_cand == c_LAST) begin
                        r_state <= c_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_cand <= r_cand + 6'd1;
                    end
                end
                c_HOLD: begin
                    if (sol_ready) begin
                        sol_count <= w_count_next;
                        sol_valid <= 1'b0;
                        if ((r_cand == c_LAST) || w_limit) begin
                            r_state <= c_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= c_SCAN;
                            r_cand  <= r_cand + 6'd1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_grid_coloring_enum.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_coloring_enum
// Description : Directed scoreboard bench for grid_coloring_enum (MAX_SOL=0 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_coloring_enum;

    typedef struct {
        logic [5:0] color;
        int         cycle;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] pin_mask = 6'd0;
    logic [5:0] pin_val = 6'd0;
    logic       sol_ready = 1'b1;
    logic       sel = 1'b0;

    logic       v0, v1, b0, b1, d0, d1;
    logic [5:0] c0, c1;
    logic [6:0] n0, n1;

    logic       w_valid, w_busy, w_done;
    logic [5:0] w_color;
    logic [6:0] w_count;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    grid_coloring_enum #(.MAX_SOL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pin_mask(pin_mask), .pin_val(pin_val), .sol_valid(v0),
        .sol_ready(sol_ready), .sol_color(c0), .sol_count(n0),
        .busy(b0), .done(d0)
    );

    grid_coloring_enum #(.MAX_SOL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pin_mask(pin_mask), .pin_val(pin_val), .sol_valid(v1),
        .sol_ready(sol_ready), .sol_color(c1), .sol_count(n1),
        .busy(b1), .done(d1)
    );

    assign w_valid = sel ? v1 : v0;
    assign w_busy  = sel ? b1 : b0;
    assign w_done  = sel ? d1 : d0;
    assign w_color = sel ? c1 : c0;
    assign w_count = sel ? n1 : n0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] color, input int cycle);
        exp_t e;
        e.color = color;
        e.cycle = cycle;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycle k is the k-th cycle after the edge that samples start.
    task automatic run(input string name, input logic [5:0] pm, input logic [5:0] pv,
                       input int stall, input int exp_done, input logic [6:0] exp_cnt);
        int   cyc;
        int   left;
        bit   stalled;
        bit   finished;
        exp_t e;
        pin_mask  = pm;
        pin_val   = pv;
        sol_ready = 1'b1;
        cyc       = 0;
        left      = stall;
        stalled   = 1'b0;
        finished  = 1'b0;
        pulse_start();
        for (int i = 0; i < 200 && !finished; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({name, "_busy_c1"}, 32'(w_busy), 32'd1);
            if (w_valid && !stalled && left > 0) stalled = 1'b1;
            if (w_valid && stalled && left > 0) begin
                sol_ready = 1'b0;
                check({name, "_stall_color"}, 32'(w_color), 32'h15);
                left--;
            end else begin
                sol_ready = 1'b1;
            end
            if (w_valid && sol_ready) begin
                if (sb.size() == 0) begin
                    check({name, "_unexpected_sol"}, 32'(w_color), 32'hFF);
                end else begin
                    e = sb.pop_front();
                    check({name, "_sol_color"}, 32'(w_color), 32'(e.color));
                    check({name, "_sol_cycle"}, 32'(cyc), 32'(e.cycle));
                end
            end
            if (w_done) begin
                finished = 1'b1;
                check({name, "_done_cycle"}, 32'(cyc), 32'(exp_done));
                check({name, "_count"}, 32'(w_count), 32'(exp_cnt));
            end
        end
        check({name, "_finished"}, 32'(finished), 32'd1);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
        sb.delete();
        sol_ready = 1'b1;
        for (int i = 0; i < 200 && !(d0 && d1); i++) @(negedge clk);
    endtask

    initial begin : stim
        bit seen;
        #12;
        check("reset_valid", 32'({v0, v1}), 32'd0);
        check("reset_flags", 32'({b0, d0, b1, d1}), 32'd0);
        check("reset_data", 32'({c0, n0}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        push(6'h15, 23); push(6'h2A, 45);
        run("unpinned", 6'h00, 6'h00, 0, 67, 7'd2);

        push(6'h15, 23);
        run("pin_v0", 6'h01, 6'h01, 0, 66, 7'd1);

        run("pin_conflict", 6'h03, 6'h03, 0, 65, 7'd0);

        push(6'h15, 33); push(6'h2A, 55);
        run("backpressure", 6'h00, 6'h00, 10, 77, 7'd2);

        sel = 1'b1;
        push(6'h15, 23);
        run("max_sol1", 6'h00, 6'h00, 0, 24, 7'd1);
        sel = 1'b0;

        // Abort while a solution is held, then a start/abort collision.
        pin_mask  = 6'h00;
        pin_val   = 6'h00;
        sol_ready = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = v0;
        end
        check("abort_hold_reached", 32'(seen), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_flags", 32'({v0, b0, d0}), 32'd0);
        check("abort_count_held", 32'(n0), 32'd0);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        check("collide_flags", 32'({v0, b0, d0}), 32'd0);
        @(negedge clk);
        check("collide_idle", 32'({v0, b0, d0}), 32'd0);
        for (int i = 0; i < 200 && !(d0 && d1); i++) begin
            @(negedge clk);
            sol_ready = 1'b1;
        end
        push(6'h15, 23); push(6'h2A, 45);
        run("restart", 6'h00, 6'h00, 0, 67, 7'd2);

        // Asynchronous reset in the middle of a sweep.
        pulse_start();
        repeat (10) @(negedge clk);
        check("pre_reset_busy", 32'(b0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_flags", 32'({v0, b0, d0}), 32'd0);
        check("rst_mid_data", 32'({c0, n0}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_stays_idle", 32'({v0, b0, d0}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
